bk_save_xfer: RTL and testbench
===============================

# bk_save_xfer

Backup-RAM save engine: on a save request, copies the backup SRAM image out of SDRAM, one 512-byte sector at a time, into a sector buffer, then hands each sector to the HPS via the `sd_wr`/`sd_ack` block-device protocol. It is the write-direction counterpart of the backup-RAM load path in the core top level. It shares the SDRAM low-speed port with the ROM loader and the load path through a toggle req/ack handshake.

## Interface
Parameters:
- `BASE_A`, `25'h0`: SDRAM byte address of backup SRAM sector 0; set to `memif_sdram.SRAM_BASE_A` at instantiation.
- `NUM_LBA`, `64`: number of 512-byte sectors saved per request.

Ports:
- `clk_sys`  in  1  system clock; everything in this block is synchronous to it.
- `reset`  in  1  synchronous, active-high reset.
- `bk_ena`  in  1  backup image mounted; save requests are ignored while 0.
- `bk_save`  in  1  save request, level or pulse; sampled only in IDLE.
- `busy`  out  1  high from request acceptance until the last sector is acknowledged.
- `sd_lba`  out  32  sector number being written.
- `sd_wr`  out  1  block write request to the HPS.
- `sd_ack`  in  1  HPS transfer acknowledge.
- `sd_buff_addr`  in  8  HPS word index into the sector buffer.
- `sd_buff_din`  out  16  sector-buffer word returned to the HPS.
- `rd_a`  out  25  SDRAM byte address of the current read.
- `rd_req`  out  1  toggle: a new read is pending when `rd_req != rd_ack`.
- `rd_ack`  in  1  toggle: the read completes when it equals `rd_req`.
- `rd_d`  in  16  read data; valid in the cycle `rd_ack` becomes equal to `rd_req`.

## Operation
- States: IDLE, FILL_REQ, FILL_WAIT, START_SD_WR, SD_WR, NEXT_LBA.
- IDLE:
  - if `bk_save & bk_ena`, set `busy=1`, `sd_lba=0`, word index `w=0`, then go to FILL_REQ.
  - otherwise stay in IDLE.
- FILL_REQ:
  - set `rd_a = BASE_A + {sd_lba, 9'b0} + {w, 1'b0}`, truncated to 25 bits.
  - toggle `rd_req`, then go to FILL_WAIT.
- FILL_WAIT: when `rd_req == rd_ack`:
  - write `rd_d` into buffer word `w`.
  - if `w == 255`, go to START_SD_WR.
  - otherwise `w <= w + 1` and go back to FILL_REQ.
  - `w` wraps at 8 bits.
- START_SD_WR: set `sd_wr=1`, then go to SD_WR.
- SD_WR:
  - on the rising edge of `sd_ack` (seen on the registered `sd_ack_d`), clear `sd_wr`.
  - on the falling edge of `sd_ack`, go to NEXT_LBA.
- NEXT_LBA:
  - if `sd_lba == NUM_LBA-1`, set `sd_lba=0`, `busy=0`, and go to IDLE.
  - otherwise `sd_lba <= sd_lba + 1`, `w <= 0`, and go to FILL_REQ.
- `bk_save` arriving while busy: ignored; no queueing.
- `bk_ena` dropping mid-save: the current save still completes.
- The buffer is not written while in SD_WR, so the HPS always reads a stable sector.

## Timing
- Reset values: `busy=0`, `sd_wr=0`, `sd_lba=0`, `rd_req=0`, `rd_a=0`, state IDLE.
- `sd_buff_din` after reset is undefined until the first fill.
- Reset mid-transfer returns to IDLE within one cycle and drops `sd_wr`. The SDRAM-side arbiter shares the same reset, so the toggle pair realigns.
- `sd_buff_din` has a 1-cycle latency from `sd_buff_addr` (registered RAM read port).
- At most one SDRAM read is outstanding.
- Minimum spacing between read requests: 2 cycles (FILL_REQ → FILL_WAIT → FILL_REQ).
- `busy` rises the cycle after `bk_save` is sampled in IDLE. It falls the cycle after NEXT_LBA for the last sector.
- `sd_ack` is used only through a one-cycle registered copy. `sd_wr` clears 2 cycles after `sd_ack` rises.

## Structure
- Shared package `core_pkg`:
  - `bksave_st_t` enum (4-bit).
  - `SECTOR_WORDS = 256`.
  - `BK_NUM_LBA = 64`.
- Sub-module: the existing `dpram`, instantiated with `addr_width=8`, `data_width=16`, as `sdbuf`.
  - Port A: HPS side (`sd_buff_addr`, read-only).
  - Port B: fill side, write enable asserted in FILL_WAIT on ack.
- Top-level change: the SDRAM low-speed port arbitration gains a read path. The `rd_req ^ rd_ack` toggle-XOR muxing uses the same scheme as the ROM loader and load paths.

## Test plan
- Single save, `NUM_LBA=2`: SDRAM model returns `rd_d = rd_a[16:1]` after a random 1–8 cycle delay.
  - Expect 512 reads at addresses `BASE_A` through `BASE_A+0x3FE`.
  - Expect two `sd_wr` pulses, with `sd_lba` = 0 then 1.
  - HPS reading sector 1 word 5 gets `0x0105`.
- Full 64-sector save with `BASE_A=25'h0100000`:
  - last read address is `0x0107FFE`.
  - `busy` is high for the whole save and drops after `sd_lba=63` is acknowledged.
  - `sd_lba` returns to 0.
- `bk_save` held high through and after completion:
  - exactly one save per IDLE sample, so a held request restarts after completion.
  - a pulse issued while busy causes no extra traffic.
- `bk_ena=0` with `bk_save=1`: no `rd_req` toggle, no `sd_wr`, and `busy` stays 0.
- `reset` asserted during FILL_WAIT of sector 3, with `sd_wr` high in a second run:
  - next cycle: IDLE, `sd_wr=0`, `busy=0`, `sd_lba=0`.
  - a following save starts cleanly at sector 0.
- Slow HPS: `sd_ack` rises 100 cycles after `sd_wr` and stays high 300 cycles.
  - `sd_wr` drops 2 cycles after `sd_ack` rises.
  - no fill reads are issued until `sd_ack` falls.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core: backup-RAM save FSM states and sector geometry.
package core_pkg;

  typedef enum logic [3:0] {
    BK_IDLE,
    BK_FILL_REQ,
    BK_FILL_WAIT,
    BK_START_SD_WR,
    BK_SD_WR,
    BK_NEXT_LBA
  } bksave_st_t;

  localparam int SECTOR_WORDS = 256;
  localparam int BK_NUM_LBA   = 64;

endpackage

// File: rtl/dpram.sv
// Two-port RAM: port A registered read, port B write, one clock.
module dpram #(
  parameter int addr_width = 8,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic [addr_width-1:0] addr_a,
  output logic [data_width-1:0] q_a,
  input  logic [addr_width-1:0] addr_b,
  input  logic [data_width-1:0] data_b,
  input  logic                  wren_b
);

  logic [data_width-1:0] mem [0:(1<<addr_width)-1];

  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // undefined until written, and readers must not rely on them before that.
  always_ff @(posedge clk) begin
    if (wren_b) mem[addr_b] <= data_b;
    q_a <= mem[addr_a];
  end

endmodule

// File: rtl/bk_save_xfer.sv
// Backup-RAM save engine: copies the SRAM image from SDRAM sector by sector into
// a buffer, then hands each sector to the HPS over the sd_wr/sd_ack protocol.
module bk_save_xfer
  import core_pkg::*;
#(
  parameter logic [24:0] BASE_A  = 25'h0,
  parameter int          NUM_LBA = BK_NUM_LBA
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic        bk_save,
  output logic        busy,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_din,
  output logic [24:0] rd_a,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [15:0] rd_d
);

  bksave_st_t  state, state_nxt;
  logic [7:0]  w, w_nxt;
  logic [31:0] lba_nxt;
  logic [24:0] rd_a_nxt;
  logic        busy_nxt, sd_wr_nxt, rd_req_nxt;
  logic        sd_ack_d;
  logic        buf_we;
  logic        rd_done;

  assign rd_done = (rd_req == rd_ack);

  // NOTE: every register here is updated with <= so all of them sample the
  // same pre-edge values; blocking writes would leak new values into later lines.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= BK_IDLE;
      busy     <= 1'b0;
      sd_wr    <= 1'b0;
      sd_lba   <= '0;
      rd_req   <= 1'b0;
      rd_a     <= '0;
      w        <= '0;
      sd_ack_d <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      sd_wr    <= sd_wr_nxt;
      sd_lba   <= lba_nxt;
      rd_req   <= rd_req_nxt;
      rd_a     <= rd_a_nxt;
      w        <= w_nxt;
      sd_ack_d <= sd_ack;
    end
  end

  // NOTE: each output gets a hold-value default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    busy_nxt   = busy;
    sd_wr_nxt  = sd_wr;
    lba_nxt    = sd_lba;
    rd_req_nxt = rd_req;
    rd_a_nxt   = rd_a;
    w_nxt      = w;
    buf_we     = 1'b0;
    case (state)
      BK_IDLE: begin
        if (bk_save && bk_ena) begin
          busy_nxt  = 1'b1;
          lba_nxt   = '0;
          w_nxt     = '0;
          state_nxt = BK_FILL_REQ;
        end
      end
      BK_FILL_REQ: begin
        rd_a_nxt   = BASE_A + {sd_lba[15:0], 9'b0} + {16'b0, w, 1'b0};
        rd_req_nxt = ~rd_req;
        state_nxt  = BK_FILL_WAIT;
      end
      BK_FILL_WAIT: begin
        if (rd_done) begin
          buf_we = 1'b1;
          if (w == 8'(SECTOR_WORDS - 1)) begin
            state_nxt = BK_START_SD_WR;
          end else begin
            w_nxt     = w + 8'd1;
            state_nxt = BK_FILL_REQ;
          end
        end
      end
      BK_START_SD_WR: begin
        sd_wr_nxt = 1'b1;
        state_nxt = BK_SD_WR;
      end
      BK_SD_WR: begin
        // sd_wr still high means the ack has not risen yet; once it has, wait for it to fall.
        if (sd_wr && sd_ack_d)        sd_wr_nxt = 1'b0;
        else if (!sd_wr && !sd_ack_d) state_nxt = BK_NEXT_LBA;
      end
      BK_NEXT_LBA: begin
        if (sd_lba == 32'(NUM_LBA - 1)) begin
          lba_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = BK_IDLE;
        end else begin
          lba_nxt   = sd_lba + 32'd1;
          w_nxt     = '0;
          state_nxt = BK_FILL_REQ;
        end
      end
      default: state_nxt = BK_IDLE;
    endcase
  end

  dpram #(.addr_width(8), .data_width(16)) sdbuf (
    .clk    (clk_sys),
    .addr_a (sd_buff_addr),
    .q_a    (sd_buff_din),
    .addr_b (w),
    .data_b (rd_d),
    .wren_b (buf_we)
  );

endmodule

// File: tb/tb_bk_save_xfer.sv
// Bench for bk_save_xfer: two instances (2-sector at base 0, 64-sector at 0x0100000)
// driven by an SDRAM toggle model and an HPS model, checked against address/data rules.
module tb_bk_save_xfer;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset        [2];
  logic        bk_ena       [2];
  logic        bk_save      [2];
  logic        busy         [2];
  logic [31:0] sd_lba       [2];
  logic        sd_wr        [2];
  logic        sd_ack       [2];
  logic [7:0]  sd_buff_addr [2];
  logic [15:0] sd_buff_din  [2];
  logic [24:0] rd_a         [2];
  logic        rd_req       [2];
  logic        rd_ack       [2];
  logic [15:0] rd_d         [2];

  int total = 0;
  int bad   = 0;

  int          rd_cnt   [2] = '{0, 0};
  int          wr_cnt   [2] = '{0, 0};
  int          hps_done [2] = '{0, 0};
  int          rd_base  [2] = '{0, 0};
  int          wr_base  [2] = '{0, 0};
  int          hd_base  [2] = '{0, 0};
  int          dmin     [2] = '{1, 1};
  int          dmax     [2] = '{8, 1};
  int          ack_dly  [2] = '{1, 1};
  int          ack_hold [2] = '{258, 258};
  bit          hps_en   [2] = '{1'b1, 1'b1};
  logic [24:0] last_rd  [2];
  logic [15:0] w5_l1    [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int num_lba(int g);
    return (g == 0) ? 2 : 64;
  endfunction

  function automatic int base_a(int g);
    return (g == 0) ? 0 : 32'h0100000;
  endfunction

  // n-th read of a save covers the image linearly, two bytes per word
  function automatic logic [24:0] exp_addr(int g, int n);
    return 25'(base_a(g) + 2 * (n % (num_lba(g) * 256)));
  endfunction

  function automatic logic [15:0] exp_word(int g, int lba, int k);
    logic [24:0] a;
    a = 25'(base_a(g) + lba * 512 + 2 * k);
    return a[16:1];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    bk_save_xfer #(
      .BASE_A  ((g == 0) ? 25'h0 : 25'h0100000),
      .NUM_LBA ((g == 0) ? 2 : 64)
    ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset[g]),
      .bk_ena       (bk_ena[g]),
      .bk_save      (bk_save[g]),
      .busy         (busy[g]),
      .sd_lba       (sd_lba[g]),
      .sd_wr        (sd_wr[g]),
      .sd_ack       (sd_ack[g]),
      .sd_buff_addr (sd_buff_addr[g]),
      .sd_buff_din  (sd_buff_din[g]),
      .rd_a         (rd_a[g]),
      .rd_req       (rd_req[g]),
      .rd_ack       (rd_ack[g]),
      .rd_d         (rd_d[g])
    );

    // SDRAM port: answers each toggle after a random delay; shares the DUT reset
    initial begin : sdram
      int d;
      bit aborted;
      rd_ack[g] = 1'b0;
      rd_d[g]   = '0;
      forever begin
        @(posedge clk_sys); #1;
        if (reset[g]) begin
          rd_ack[g] = 1'b0;
        end else if (rd_req[g] != rd_ack[g]) begin
          check("rd_a sequence", 64'(rd_a[g]), 64'(exp_addr(g, rd_cnt[g] - rd_base[g])));
          check("read while sd_ack high", 64'(sd_ack[g]), 64'(0));
          d = int'($urandom_range(dmax[g], dmin[g]));
          aborted = 1'b0;
          for (int c = 1; c < d; c++) begin
            @(posedge clk_sys); #1;
            if (reset[g]) begin
              aborted = 1'b1;
              break;
            end
          end
          if (aborted) begin
            rd_ack[g] = 1'b0;
          end else begin
            rd_d[g]    = rd_a[g][16:1];
            rd_ack[g]  = rd_req[g];
            last_rd[g] = rd_a[g];
            rd_cnt[g]++;
          end
        end
      end
    end

    // HPS: acks each sd_wr, reads the whole sector back while ack is high
    initial begin : hps
      int lba;
      sd_ack[g]       = 1'b0;
      sd_buff_addr[g] = '0;
      forever begin
        @(posedge clk_sys); #1;
        if (hps_en[g] && sd_wr[g] === 1'b1 && !reset[g]) begin
          lba = (wr_cnt[g] - wr_base[g]) % num_lba(g);
          check("sd_lba at sd_wr", 64'(sd_lba[g]), 64'(lba));
          wr_cnt[g]++;
          repeat (ack_dly[g]) @(posedge clk_sys);
          #1;
          sd_ack[g]       = 1'b1;
          sd_buff_addr[g] = '0;
          for (int c = 0; c < ack_hold[g]; c++) begin
            @(posedge clk_sys); #1;
            if (c == 0) check("sd_wr 1 cycle after ack", 64'(sd_wr[g]), 64'(1));
            if (c == 1) check("sd_wr 2 cycles after ack", 64'(sd_wr[g]), 64'(0));
            if (c < 256) begin
              check("sector word", 64'(sd_buff_din[g]), 64'(exp_word(g, lba, c)));
              if (lba == 1 && c == 5) w5_l1[g] = sd_buff_din[g];
            end
            sd_buff_addr[g] = 8'(c + 1);
          end
          sd_ack[g] = 1'b0;
          hps_done[g]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys); #2;
  endtask

  task automatic mark(input int g);
    rd_base[g] = rd_cnt[g];
    wr_base[g] = wr_cnt[g];
    hd_base[g] = hps_done[g];
  endtask

  task automatic pulse_save(input int g);
    bk_save[g] = 1'b1;
    step();
    bk_save[g] = 1'b0;
    check("busy after accept", 64'(busy[g]), 64'(1));
  endtask

  task automatic wait_idle(input int g, input int bound, input string name);
    int n = 0;
    while (busy[g] && n < bound) begin
      step();
      n++;
    end
    check(name, 64'(busy[g]), 64'(0));
  endtask

  typedef struct {
    bit rst;
    bit ena;
    bit save;
    bit exp_busy;
    bit exp_rdreq;
  } vec_t;

  vec_t vt [8];

  initial begin
    int n;
    bit moved;
    logic rr;

    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int g = 0; g < 2; g++) begin
      reset[g]   = 1'b1;
      bk_ena[g]  = 1'b0;
      bk_save[g] = 1'b0;
    end
    repeat (2) step();
    for (int g = 0; g < 2; g++) begin
      check("reset busy",   64'(busy[g]),   64'(0));
      check("reset sd_wr",  64'(sd_wr[g]),  64'(0));
      check("reset sd_lba", 64'(sd_lba[g]), 64'(0));
      check("reset rd_req", 64'(rd_req[g]), 64'(0));
      check("reset rd_a",   64'(rd_a[g]),   64'(0));
    end
    reset[1] = 1'b0;

    // accept/ignore rules around IDLE, with a reset right after the first read toggle
    for (int i = 0; i < 8; i++) begin
      reset[0]   = vt[i].rst;
      bk_ena[0]  = vt[i].ena;
      bk_save[0] = vt[i].save;
      step();
      check($sformatf("vec%0d busy", i),   64'(busy[0]),   64'(vt[i].exp_busy));
      check($sformatf("vec%0d rd_req", i), 64'(rd_req[0]), 64'(vt[i].exp_rdreq));
      check($sformatf("vec%0d sd_wr", i),  64'(sd_wr[0]),  64'(0));
    end
    step();

    // single 2-sector save, with a request pulse while busy
    mark(0);
    ack_dly[0] = int'($urandom_range(5, 0));
    bk_ena[0]  = 1'b1;
    pulse_save(0);
    repeat (100) step();
    pulse_save(0);
    wait_idle(0, 20000, "save1 completes");
    check("save1 reads",     64'(rd_cnt[0] - rd_base[0]),     64'(512));
    check("save1 last rd_a", 64'(last_rd[0]),                 64'(25'h3FE));
    check("save1 sd_wr cnt", 64'(wr_cnt[0] - wr_base[0]),     64'(2));
    check("save1 acks",      64'(hps_done[0] - hd_base[0]),   64'(2));
    check("sector1 word5",   64'(w5_l1[0]),                   64'(16'h0105));
    check("save1 sd_lba",    64'(sd_lba[0]),                  64'(0));

    // held request restarts once after completion, then stops when released
    mark(0);
    bk_save[0] = 1'b1;
    step();
    check("held busy", 64'(busy[0]), 64'(1));
    wait_idle(0, 20000, "held first completes");
    check("held first reads", 64'(rd_cnt[0] - rd_base[0]), 64'(512));
    step();
    check("held restarts", 64'(busy[0]), 64'(1));
    bk_save[0] = 1'b0;
    wait_idle(0, 20000, "held second completes");
    repeat (20) step();
    check("held stays idle", 64'(busy[0]), 64'(0));
    check("held reads",      64'(rd_cnt[0] - rd_base[0]), 64'(1024));
    check("held sd_wr cnt",  64'(wr_cnt[0] - wr_base[0]), 64'(4));

    // request while not mounted
    bk_ena[0]  = 1'b0;
    bk_save[0] = 1'b1;
    rr    = rd_req[0];
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy[0] || sd_wr[0] || rd_req[0] != rr) moved = 1'b1;
    end
    check("unmounted ignored", 64'(moved), 64'(0));
    bk_save[0] = 1'b0;
    bk_ena[0]  = 1'b1;

    // slow HPS
    mark(0);
    ack_dly[0]  = 100;
    ack_hold[0] = 300;
    pulse_save(0);
    wait_idle(0, 20000, "slow save completes");
    check("slow reads", 64'(rd_cnt[0] - rd_base[0]),   64'(512));
    check("slow acks",  64'(hps_done[0] - hd_base[0]), 64'(2));

    // reset during FILL_WAIT of sector 3
    mark(1);
    dmin[1]   = 4;
    dmax[1]   = 4;
    bk_ena[1] = 1'b1;
    pulse_save(1);
    n = 0;
    while (!(sd_lba[1] == 32'd3 && rd_req[1] != rd_ack[1]) && n < 20000) begin
      step();
      n++;
    end
    check("reached sector3 fill", 64'(n < 20000), 64'(1));
    reset[1] = 1'b1;
    step();
    check("rst fill busy",   64'(busy[1]),   64'(0));
    check("rst fill sd_wr",  64'(sd_wr[1]),  64'(0));
    check("rst fill sd_lba", 64'(sd_lba[1]), 64'(0));
    check("rst fill rd_req", 64'(rd_req[1]), 64'(0));
    reset[1] = 1'b0;
    step();

    // restart cleanly, then reset while sd_wr is high
    mark(1);
    hps_en[1] = 1'b0;
    dmin[1]   = 1;
    dmax[1]   = 1;
    pulse_save(1);
    check("restart sd_lba", 64'(sd_lba[1]), 64'(0));
    n = 0;
    while (sd_wr[1] !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check("restart reaches sd_wr", 64'(n < 2000), 64'(1));
    check("restart reads",         64'(rd_cnt[1] - rd_base[1]), 64'(256));
    check("restart sd_wr sd_lba",  64'(sd_lba[1]), 64'(0));
    reset[1] = 1'b1;
    step();
    check("rst wr busy",   64'(busy[1]),   64'(0));
    check("rst wr sd_wr",  64'(sd_wr[1]),  64'(0));
    check("rst wr sd_lba", 64'(sd_lba[1]), 64'(0));
    reset[1]  = 1'b0;
    hps_en[1] = 1'b1;
    step();

    // full 64-sector save
    mark(1);
    ack_dly[1]  = 1;
    ack_hold[1] = 257;
    pulse_save(1);
    n = 0;
    while (busy[1] && n < 80000) begin
      step();
      n++;
    end
    check("full save completes", 64'(busy[1]), 64'(0));
    check("full acks before idle", 64'(hps_done[1] - hd_base[1]), 64'(64));
    check("full reads",            64'(rd_cnt[1] - rd_base[1]),   64'(16384));
    check("full last rd_a",        64'(last_rd[1]),               64'(25'h0107FFE));
    check("full sd_lba back to 0", 64'(sd_lba[1]),                64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
